// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//
// Memory-mapped interrupt controller that funnels up to NUM_SRC peripheral
// interrupt lines onto the single interrupt input of cp0. Rising edges on the
// source lines are latched into a pending register and filtered by a software
// mask. One winner is then picked by round-robin priority and held in service
// until software writes EOI or the core executes ERET.
//
// Register block (word offsets from BASE_ADDR, address[1:0] ignored):
//   +0  PENDING  read pending, write-1-to-clear
//   +4  MASK     read/write enable mask
//   +8  CLAIM    in-service source index in SERVICE, else all ones
//   +12 EOI      any write ends service, reads 0
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   irq_src        raw interrupt lines, rising-edge sensitive
//   address        ALU-computed data address
//   data           store data
//   MemRead        load strobe
//   MemWrite       store strobe
//   TakenInterrupt cp0 accepted the interrupt this cycle
//   ERET           ERET executing this cycle
//   IrqAddress     address hits the register block (gates data_mem enables)
//   rd_data        register read data, 0 when not a read hit
//   irq            registered interrupt request to cp0
//   claim_id       in-service source index
// -----------------------------------------------------------------------------
module irq_controller #(
   parameter int          NUM_SRC   = 8,
   parameter logic [31:0] BASE_ADDR = 32'hFFFF0020
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [31:0]        address,
   input  logic [31:0]        data,
   input  logic               MemRead,
   input  logic               MemWrite,
   input  logic               TakenInterrupt,
   input  logic               ERET,
   output logic               IrqAddress,
   output logic [31:0]        rd_data,
   output logic               irq,
   output logic [4:0]         claim_id
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQUEST = 2'd1;
   localparam logic [1:0] SERVICE = 2'd2;

   localparam logic [1:0] OFS_PENDING = 2'd0;
   localparam logic [1:0] OFS_MASK    = 2'd1;
   localparam logic [1:0] OFS_CLAIM   = 2'd2;
   localparam logic [1:0] OFS_EOI     = 2'd3;

   localparam logic [4:0] LAST_RESET = 5'(NUM_SRC - 1);

   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] pending_next;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] w1c_clr;
   logic [NUM_SRC-1:0] grant_clr;
   logic [31:0]        eligible_w;
   logic [1:0]         state;
   logic [1:0]         state_next;
   logic [4:0]         last_served;
   logic [4:0]         winner;
   logic               found;
   logic [5:0]         start_idx;
   logic [5:0]         cand;
   logic               wr_hit;
   logic               pend_wr;
   logic               mask_wr;
   logic               eoi_wr;
   logic               grant;
   logic               unused_bits;

   // Low address bits and the upper store-data bits have no meaning here.
   assign unused_bits = ^{address[1:0], data};

   assign IrqAddress = (address[31:4] == BASE_ADDR[31:4]);
   assign wr_hit     = IrqAddress & MemWrite;
   assign pend_wr    = wr_hit & (address[3:2] == OFS_PENDING);
   assign mask_wr    = wr_hit & (address[3:2] == OFS_MASK);
   assign eoi_wr     = wr_hit & (address[3:2] == OFS_EOI);

   assign eligible   = pending & mask;
   assign eligible_w = 32'(eligible);
   assign rise       = irq_src & ~src_q;
   assign grant      = (state == REQUEST) & TakenInterrupt & found;

   // Round-robin search: start one past the last served source and wrap.
   // The candidate index never exceeds 2*NUM_SRC-2, so one subtraction
   // is enough to bring it back into range.
   always_comb begin
      winner    = '0;
      found     = 1'b0;
      cand      = '0;
      start_idx = {1'b0, last_served} + 6'd1;
      if (start_idx >= 6'(NUM_SRC)) begin
         start_idx = '0;
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = start_idx + 6'(k);
         if (cand >= 6'(NUM_SRC)) begin
            cand = cand - 6'(NUM_SRC);
         end
         if (!found && eligible_w[cand[4:0]]) begin
            found  = 1'b1;
            winner = cand[4:0];
         end
      end
   end

   // Pending update: software clear and grant clear first, then new edges
   // are OR'd in so that a fresh edge always survives a same-cycle clear.
   always_comb begin
      w1c_clr   = pend_wr ? data[NUM_SRC-1:0] : '0;
      grant_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         grant_clr[i] = grant && (winner == 5'(i));
      end
      pending_next = (pending & ~w1c_clr & ~grant_clr) | rise;
   end

   // Next-state logic. Decisions use register values from before the edge.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (eligible != '0) begin
               state_next = REQUEST;
            end
         end
         REQUEST: begin
            if (grant) begin
               state_next = SERVICE;
            end else if (!found) begin
               state_next = IDLE;
            end
         end
         SERVICE: begin
            if (eoi_wr || ERET) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Register read mux; combinational so the load completes in its own cycle.
   always_comb begin
      rd_data = '0;
      if (IrqAddress && MemRead) begin
         case (address[3:2])
            OFS_PENDING: rd_data = 32'(pending);
            OFS_MASK:    rd_data = 32'(mask);
            OFS_CLAIM:   rd_data = (state == SERVICE) ? {27'b0, claim_id} : 32'hFFFFFFFF;
            default:     rd_data = '0;
         endcase
      end
   end

   // All controller state. irq is registered from the next state so cp0
   // sees a clean, glitch-free request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending     <= '0;
         mask        <= '0;
         src_q       <= '0;
         state       <= IDLE;
         last_served <= LAST_RESET;
         claim_id    <= '0;
         irq         <= 1'b0;
      end else begin
         src_q   <= irq_src;
         pending <= pending_next;
         state   <= state_next;
         irq     <= (state_next == REQUEST);
         if (mask_wr) begin
            mask <= data[NUM_SRC-1:0];
         end
         if (grant) begin
            claim_id    <= winner;
            last_served <= winner;
         end
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
//
// Directed, self-checking bench for irq_controller. A table of per-cycle
// input vectors with hand-computed outputs covers basic claim/EOI flow and
// round-robin ordering; short hand-written sequences cover service hold-off,
// ERET, masking, W1C races, address decode and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_irq_controller;

   localparam int          NUM_SRC = 8;
   localparam logic [31:0] BASE    = 32'hFFFF0020;
   localparam logic [31:0] A_PEND  = BASE + 32'd0;
   localparam logic [31:0] A_MASK  = BASE + 32'd4;
   localparam logic [31:0] A_CLAIM = BASE + 32'd8;
   localparam logic [31:0] A_EOI   = BASE + 32'd12;
   localparam logic [31:0] NONE    = 32'hFFFFFFFF;
   localparam int          NVEC    = 30;

   logic               clk;
   logic               reset;
   logic [NUM_SRC-1:0] irq_src;
   logic [31:0]        address;
   logic [31:0]        data;
   logic               MemRead;
   logic               MemWrite;
   logic               TakenInterrupt;
   logic               ERET;
   logic               IrqAddress;
   logic [31:0]        rd_data;
   logic               irq;
   logic [4:0]         claim_id;

   int checks;
   int errors;

   typedef struct {
      logic [NUM_SRC-1:0] src;
      logic [31:0]        addr;
      logic [31:0]        wdata;
      logic               rd;
      logic               wr;
      logic               taken;
      logic               eret;
      logic               exp_irq;
      logic               exp_hit;
      logic [31:0]        exp_rd;
   } vec_t;

   vec_t vecs [NVEC];

   irq_controller #(
      .NUM_SRC   (NUM_SRC),
      .BASE_ADDR (BASE)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .irq_src        (irq_src),
      .address        (address),
      .data           (data),
      .MemRead        (MemRead),
      .MemWrite       (MemWrite),
      .TakenInterrupt (TakenInterrupt),
      .ERET           (ERET),
      .IrqAddress     (IrqAddress),
      .rd_data        (rd_data),
      .irq            (irq),
      .claim_id       (claim_id)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic [NUM_SRC-1:0] src, logic [31:0] addr,
                               logic [31:0] wdata, logic rd, logic wr,
                               logic taken, logic eret, logic exp_irq,
                               logic exp_hit, logic [31:0] exp_rd);
      vec_t v;
      v.src = src; v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr;
      v.taken = taken; v.eret = eret; v.exp_irq = exp_irq;
      v.exp_hit = exp_hit; v.exp_rd = exp_rd;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      irq_src        = v.src;
      address        = v.addr;
      data           = v.wdata;
      MemRead        = v.rd;
      MemWrite       = v.wr;
      TakenInterrupt = v.taken;
      ERET           = v.eret;
   endtask

   // Advance one clock and land just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      irq_src = '0; address = '0; data = '0; MemRead = 1'b0; MemWrite = 1'b0;
      TakenInterrupt = 1'b0; ERET = 1'b0;
   endtask

   task automatic readReg(input logic [31:0] addr, input logic [31:0] expected,
                          input string name);
      address = addr;
      MemRead = 1'b1;
      #1;
      checkOutput(name, rd_data, expected);
      MemRead = 1'b0;
      address = '0;
   endtask

   task automatic writeReg(input logic [31:0] addr, input logic [31:0] value);
      address  = addr;
      data     = value;
      MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0;
      address  = '0;
      data     = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // Claim/EOI flow with MASK=0x01, then round-robin over sources 2 and 5.
      vecs[0]  = mk(8'h00, A_MASK,  32'h01, 0, 1, 0, 0, 0, 1, 32'h0);
      vecs[1]  = mk(8'h01, A_MASK,  32'h00, 1, 0, 0, 0, 0, 1, 32'h01);
      vecs[2]  = mk(8'h00, A_PEND,  32'h00, 1, 0, 0, 0, 0, 1, 32'h01);
      vecs[3]  = mk(8'h00, A_CLAIM, 32'h00, 1, 0, 1, 0, 1, 1, NONE);
      vecs[4]  = mk(8'h00, A_CLAIM, 32'h00, 1, 0, 0, 0, 0, 1, 32'h0);
      vecs[5]  = mk(8'h00, A_PEND,  32'h00, 1, 0, 0, 0, 0, 1, 32'h0);
      vecs[6]  = mk(8'h00, A_EOI,   32'h00, 0, 1, 0, 0, 0, 1, 32'h0);
      vecs[7]  = mk(8'h00, A_CLAIM, 32'h00, 1, 0, 0, 0, 0, 1, NONE);
      vecs[8]  = mk(8'h00, A_MASK,  32'hFF, 0, 1, 0, 0, 0, 1, 32'h0);
      vecs[9]  = mk(8'h24, A_MASK,  32'h00, 1, 0, 0, 0, 0, 1, 32'hFF);
      vecs[10] = mk(8'h24, A_PEND,  32'h00, 1, 0, 0, 0, 0, 1, 32'h24);
      vecs[11] = mk(8'h24, A_CLAIM, 32'h00, 1, 0, 1, 0, 1, 1, NONE);
      vecs[12] = mk(8'h24, A_CLAIM, 32'h00, 1, 0, 0, 0, 0, 1, 32'h2);
      vecs[13] = mk(8'h24, A_EOI,   32'h00, 0, 1, 0, 0, 0, 1, 32'h0);
      vecs[14] = mk(8'h24, A_PEND,  32'h00, 1, 0, 0, 0, 0, 1, 32'h20);
      vecs[15] = mk(8'h24, A_CLAIM, 32'h00, 1, 0, 1, 0, 1, 1, NONE);
      vecs[16] = mk(8'h24, A_CLAIM, 32'h00, 1, 0, 0, 0, 0, 1, 32'h5);
      vecs[17] = mk(8'h00, A_EOI,   32'h00, 0, 1, 0, 0, 0, 1, 32'h0);
      vecs[18] = mk(8'h00, A_PEND,  32'h00, 1, 0, 0, 0, 0, 1, 32'h0);
      vecs[19] = mk(8'h24, A_CLAIM, 32'h00, 1, 0, 0, 0, 0, 1, NONE);
      vecs[20] = mk(8'h00, A_PEND,  32'h00, 1, 0, 0, 0, 0, 1, 32'h24);
      vecs[21] = mk(8'h00, A_CLAIM, 32'h00, 1, 0, 1, 0, 1, 1, NONE);
      vecs[22] = mk(8'h00, A_CLAIM, 32'h00, 1, 0, 0, 0, 0, 1, 32'h2);
      vecs[23] = mk(8'h00, A_EOI,   32'h00, 0, 1, 0, 0, 0, 1, 32'h0);
      vecs[24] = mk(8'h00, A_PEND,  32'h00, 1, 0, 0, 0, 0, 1, 32'h20);
      vecs[25] = mk(8'h00, A_CLAIM, 32'h00, 1, 0, 1, 0, 1, 1, NONE);
      vecs[26] = mk(8'h00, A_CLAIM, 32'h00, 1, 0, 0, 0, 0, 1, 32'h5);
      vecs[27] = mk(8'h00, A_EOI,   32'h00, 0, 1, 0, 0, 0, 1, 32'h0);
      vecs[28] = mk(8'h00, 32'h10010000, 32'h00, 1, 0, 0, 0, 0, 0, 32'h0);
      vecs[29] = mk(8'h00, A_CLAIM, 32'h00, 1, 0, 0, 0, 0, 1, NONE);

      clearInputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("reset irq", 32'(irq), 32'h0);
      checkOutput("reset claim_id", 32'(claim_id), 32'h0);
      readReg(A_CLAIM, NONE, "reset CLAIM");
      readReg(A_MASK, 32'h0, "reset MASK");
      readReg(A_PEND, 32'h0, "reset PENDING");

      $display("[TB] vector table");
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
         checkOutput($sformatf("vec%0d hit", i), 32'(IrqAddress), 32'(vecs[i].exp_hit));
         checkOutput($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_rd);
         tick();
      end
      clearInputs();

      // New edge during service is held off; ERET gives one idle cycle.
      $display("[TB] service hold-off and ERET");
      irq_src = 8'h01;
      tick();
      irq_src = 8'h00;
      tick();
      checkOutput("seqA irq request", 32'(irq), 32'h1);
      TakenInterrupt = 1'b1;
      tick();
      TakenInterrupt = 1'b0;
      readReg(A_CLAIM, 32'h0, "seqA claim src0");
      irq_src = 8'h08;
      tick();
      irq_src = 8'h00;
      tick();
      checkOutput("seqA irq held in service", 32'(irq), 32'h0);
      tick();
      checkOutput("seqA irq held again", 32'(irq), 32'h0);
      ERET = 1'b1;
      tick();
      ERET = 1'b0;
      checkOutput("seqA idle after ERET", 32'(irq), 32'h0);
      tick();
      checkOutput("seqA irq after idle", 32'(irq), 32'h1);
      TakenInterrupt = 1'b1;
      tick();
      TakenInterrupt = 1'b0;
      readReg(A_CLAIM, 32'h3, "seqA claim src3");
      checkOutput("seqA claim_id port", 32'(claim_id), 32'h3);
      writeReg(A_EOI, 32'h0);
      tick();
      checkOutput("seqA irq after EOI", 32'(irq), 32'h0);

      // Masked pending, unmask, then software clear before taken.
      $display("[TB] mask and W1C withdrawal");
      writeReg(A_MASK, 32'h00);
      irq_src = 8'h10;
      tick();
      irq_src = 8'h00;
      tick();
      checkOutput("seqB irq masked", 32'(irq), 32'h0);
      readReg(A_PEND, 32'h10, "seqB pending masked");
      writeReg(A_MASK, 32'h10);
      tick();
      checkOutput("seqB irq unmasked", 32'(irq), 32'h1);
      writeReg(A_PEND, 32'h10);
      tick();
      checkOutput("seqB irq withdrawn", 32'(irq), 32'h0);
      readReg(A_PEND, 32'h0, "seqB pending cleared");
      readReg(A_CLAIM, NONE, "seqB no claim");
      TakenInterrupt = 1'b1;
      tick();
      TakenInterrupt = 1'b0;
      readReg(A_CLAIM, NONE, "seqB taken in idle ignored");
      checkOutput("seqB irq after stray taken", 32'(irq), 32'h0);

      // Same-cycle edge and W1C, MASK bits above NUM_SRC, address decode.
      $display("[TB] set/clear race and decode");
      irq_src  = 8'h02;
      address  = A_PEND;
      data     = 32'h02;
      MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0;
      irq_src  = 8'h00;
      readReg(A_PEND, 32'h02, "seqC set beats W1C");
      writeReg(A_PEND, 32'h02);
      readReg(A_PEND, 32'h0, "seqC W1C alone");
      writeReg(A_MASK, 32'hFFFF_FF10);
      readReg(A_MASK + 32'd1, 32'h10, "seqC MASK upper bits, low addr ignored");
      readReg(A_EOI, 32'h0, "seqC EOI reads 0");
      address = 32'h10010000;
      MemRead = 1'b1;
      #1;
      checkOutput("seqC non-hit IrqAddress", 32'(IrqAddress), 32'h0);
      checkOutput("seqC non-hit rd_data", rd_data, 32'h0);
      address = BASE + 32'h10;
      #1;
      checkOutput("seqC next block not hit", 32'(IrqAddress), 32'h0);
      MemRead = 1'b0;
      address = '0;

      // Async reset in the middle of service; MASK write must not disturb claim.
      $display("[TB] reset during service");
      writeReg(A_MASK, 32'h40);
      irq_src = 8'h40;
      tick();
      irq_src = 8'h00;
      tick();
      checkOutput("seqD irq request", 32'(irq), 32'h1);
      TakenInterrupt = 1'b1;
      tick();
      TakenInterrupt = 1'b0;
      readReg(A_CLAIM, 32'h6, "seqD claim src6");
      writeReg(A_MASK, 32'h00);
      readReg(A_CLAIM, 32'h6, "seqD claim survives MASK write");
      #2;
      reset = 1'b1;
      #1;
      checkOutput("seqD async irq", 32'(irq), 32'h0);
      checkOutput("seqD async claim_id", 32'(claim_id), 32'h0);
      readReg(A_CLAIM, NONE, "seqD async CLAIM");
      writeReg(A_MASK, 32'h40);
      readReg(A_MASK, 32'h0, "seqD MASK held in reset");
      reset = 1'b0;
      tick();
      readReg(A_PEND, 32'h0, "seqD pending after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
